// File: rtl/int_divide_execute_stage_pkg.sv
// Shared definitions for the integer divide/remainder execute stage.
//   div_op_t       : operation encoding (bit1 = signed, bit0 = remainder)
//   pipeline_sel_t : pipeline selects used by the scheduler
//   div_state_t    : divide sequencer states
//   DIV_LATENCY    : accept-to-valid latency at the default data width
package int_divide_execute_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DIV_LATENCY        = DEFAULT_DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    PIPE_MEM         = 2'd0,
    PIPE_INT_ARITH   = 2'd1,
    PIPE_FLOAT_ARITH = 2'd2,
    PIPE_INT_DIV     = 2'd3
  } pipeline_sel_t;

  typedef enum logic [1:0] {
    DIV_U = 2'b00,
    REM_U = 2'b01,
    DIV_S = 2'b10,
    REM_S = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_ITERATE = 2'd1,
    DIV_FIXUP   = 2'd2,
    DIV_DONE    = 2'd3
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/int_divide_execute_stage_lane.sv
// One vector lane of the restoring divider.
//   clk, reset : core clock, asynchronous active-high reset
//   load       : capture operands (magnitudes, sign flags, zero-divisor flag)
//   step       : perform one radix-2 restoring iteration
//   signed_op  : operands are two's complement (sampled with load)
//   rem_op     : select remainder instead of quotient on result
//   dividend   : raw dividend (sampled with load)
//   divisor    : raw divisor (sampled with load)
//   result     : sign-corrected quotient or remainder (combinational)
module int_divide_lane
  import int_divide_execute_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  signed_op,
  input  logic                  rem_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] quot_r;
  logic [DATA_WIDTH-1:0] divisor_r;
  logic                  q_neg_r;
  logic                  r_neg_r;
  logic                  div_zero_r;

  logic [DATA_WIDTH-1:0] dividend_abs_s;
  logic [DATA_WIDTH-1:0] divisor_abs_s;
  logic [DATA_WIDTH:0]   rem_shift_s;
  logic [DATA_WIDTH+1:0] trial_s;
  logic [DATA_WIDTH-1:0] rem_next_s;
  logic [DATA_WIDTH-1:0] quot_next_s;
  logic [DATA_WIDTH-1:0] quot_fix_s;
  logic [DATA_WIDTH-1:0] rem_fix_s;

  // Operand magnitudes for signed operations.
  always_comb begin
    dividend_abs_s = dividend;
    divisor_abs_s  = divisor;
    if (signed_op && dividend[DATA_WIDTH-1]) begin
      dividend_abs_s = -dividend;
    end else begin
      dividend_abs_s = dividend;
    end
    if (signed_op && divisor[DATA_WIDTH-1]) begin
      divisor_abs_s = -divisor;
    end else begin
      divisor_abs_s = divisor;
    end
  end

  // One restoring step. The shifted remainder can reach 2*divisor-1, so the
  // trial subtraction is carried with two guard bits and the sign bit decides.
  always_comb begin
    rem_shift_s = {rem_r, quot_r[DATA_WIDTH-1]};
    trial_s     = {1'b0, rem_shift_s} - {2'b00, divisor_r};
    rem_next_s  = rem_shift_s[DATA_WIDTH-1:0];
    quot_next_s = {quot_r[DATA_WIDTH-2:0], 1'b0};
    if (!trial_s[DATA_WIDTH+1]) begin
      rem_next_s  = trial_s[DATA_WIDTH-1:0];
      quot_next_s = {quot_r[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s  = rem_shift_s[DATA_WIDTH-1:0];
      quot_next_s = {quot_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Lane datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r      <= {DATA_WIDTH{1'b0}};
      quot_r     <= {DATA_WIDTH{1'b0}};
      divisor_r  <= {DATA_WIDTH{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (load) begin
      rem_r      <= {DATA_WIDTH{1'b0}};
      quot_r     <= dividend_abs_s;
      divisor_r  <= divisor_abs_s;
      q_neg_r    <= signed_op & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
      r_neg_r    <= signed_op & dividend[DATA_WIDTH-1];
      div_zero_r <= (divisor == {DATA_WIDTH{1'b0}});
    end else if (step) begin
      rem_r  <= rem_next_s;
      quot_r <= quot_next_s;
    end
  end

  // Sign correction and result select. A zero divisor yields an all-ones
  // quotient regardless of signedness; the remainder naturally comes out as
  // the original dividend. MIN / -1 falls out as MIN with remainder 0.
  always_comb begin
    if (div_zero_r) begin
      quot_fix_s = {DATA_WIDTH{1'b1}};
    end else if (q_neg_r) begin
      quot_fix_s = -quot_r;
    end else begin
      quot_fix_s = quot_r;
    end
    if (r_neg_r) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
    if (rem_op) begin
      result = rem_fix_s;
    end else begin
      result = quot_fix_s;
    end
  end

endmodule

// File: rtl/int_divide_execute_stage.sv
// Multi-cycle vector integer divide/remainder execute stage.
//   clk, reset              : core clock, asynchronous active-high reset
//   of_*                    : instruction from operand fetch (valid, op,
//                             operands, mask, thread, destination)
//   dx_ready                : stage can accept an instruction this cycle
//   wb_rollback_*           : rollback request from writeback
//   dx_instruction_valid    : one-cycle result strobe
//   dx_result               : per-lane quotient or remainder
//   dx_mask_value/thread/dest : fields captured at accept
//   dx_busy                 : operation in flight
module int_divide_execute_stage
  import int_divide_execute_stage_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int THREADS    = 4,
  localparam int TW        = $clog2(THREADS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            of_instruction_valid,
  input  logic [1:0]                      of_div_op,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] of_operand1,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] of_operand2,
  input  logic [NUM_LANES-1:0]            of_mask_value,
  input  logic [TW-1:0]                   of_thread_idx,
  input  logic [4:0]                      of_dest_reg,
  output logic                            dx_ready,
  input  logic                            wb_rollback_en,
  input  logic [TW-1:0]                   wb_rollback_thread_idx,
  output logic                            dx_instruction_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dx_result,
  output logic [NUM_LANES-1:0]            dx_mask_value,
  output logic [TW-1:0]                   dx_thread_idx,
  output logic [4:0]                      dx_dest_reg,
  output logic                            dx_busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t                      state_r;
  div_state_t                      state_next_s;
  logic [CW-1:0]                   count_r;
  logic                            rem_op_r;
  div_op_t                         in_op_s;
  logic                            accept_s;
  logic                            rb_hit_s;
  logic                            step_s;
  logic                            fixup_en_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_result_s;

  assign in_op_s = div_op_t'(of_div_op);

  // Handshake: an incoming instruction whose own thread is being rolled back
  // is dropped; rollback of the captured thread kills the op in flight.
  always_comb begin
    dx_ready   = (state_r == DIV_IDLE) || (state_r == DIV_DONE);
    accept_s   = of_instruction_valid && dx_ready &&
                 !(wb_rollback_en && (wb_rollback_thread_idx == of_thread_idx));
    rb_hit_s   = wb_rollback_en && (wb_rollback_thread_idx == dx_thread_idx);
    step_s     = (state_r == DIV_ITERATE);
    fixup_en_s = (state_r == DIV_FIXUP) && !rb_hit_s;
    dx_busy    = (state_r == DIV_ITERATE) || (state_r == DIV_FIXUP);
    dx_instruction_valid = (state_r == DIV_DONE) && !rb_hit_s;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (accept_s) state_next_s = DIV_ITERATE;
        else          state_next_s = DIV_IDLE;
      end
      DIV_ITERATE: begin
        if (rb_hit_s)                  state_next_s = DIV_IDLE;
        else if (count_r == {CW{1'b0}}) state_next_s = DIV_FIXUP;
        else                           state_next_s = DIV_ITERATE;
      end
      DIV_FIXUP: begin
        if (rb_hit_s) state_next_s = DIV_IDLE;
        else          state_next_s = DIV_DONE;
      end
      DIV_DONE: begin
        if (accept_s) state_next_s = DIV_ITERATE;
        else          state_next_s = DIV_IDLE;
      end
      default: state_next_s = DIV_IDLE;
    endcase
  end

  // State, iteration counter and captured instruction fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= DIV_IDLE;
      count_r       <= {CW{1'b0}};
      rem_op_r      <= 1'b0;
      dx_mask_value <= {NUM_LANES{1'b0}};
      dx_thread_idx <= {TW{1'b0}};
      dx_dest_reg   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        count_r       <= CW'(DATA_WIDTH - 1);
        rem_op_r      <= op_is_rem(in_op_s);
        dx_mask_value <= of_mask_value;
        dx_thread_idx <= of_thread_idx;
        dx_dest_reg   <= of_dest_reg;
      end else if (step_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Result register, loaded once per operation in the fixup cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx_result <= {(NUM_LANES*DATA_WIDTH){1'b0}};
    end else if (fixup_en_s) begin
      dx_result <= lane_result_s;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    int_divide_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (accept_s),
      .step     (step_s),
      .signed_op(op_is_signed(in_op_s)),
      .rem_op   (rem_op_r),
      .dividend (of_operand1[g*DATA_WIDTH +: DATA_WIDTH]),
      .divisor  (of_operand2[g*DATA_WIDTH +: DATA_WIDTH]),
      .result   (lane_result_s[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: doc/int_divide_execute_stage.md
Name: int_divide_execute_stage

Overview:
- Multi-cycle, vector-parallel integer divide/remainder stage alongside the single-cycle integer execute stage.
- Sits between operand fetch and writeback. Receives PIPE_INT_DIV instructions from operand fetch.
- Runs a radix-2 restoring division on every lane in parallel, then writes quotient or remainder back.
- Handles one instruction at a time. Uses a ready handshake so the scheduler holds issue while the stage is busy.

Parameters:
NUM_LANES, 16, vector lanes processed in parallel
DATA_WIDTH, 32, bits per lane operand/result
THREADS, 4, hardware threads per core; thread index width TW = $clog2(THREADS)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
of_instruction_valid  in  1  instruction presented
of_div_op  in  2  bit1 = signed, bit0 = return remainder (else quotient)
of_operand1  in  NUM_LANES*DATA_WIDTH  dividends, lane 0 in low bits
of_operand2  in  NUM_LANES*DATA_WIDTH  divisors
of_mask_value  in  NUM_LANES  lane write mask, passed through
of_thread_idx  in  TW  issuing thread
of_dest_reg  in  5  destination register, passed through
dx_ready  out  1  stage can accept this cycle
wb_rollback_en  in  1  rollback request
wb_rollback_thread_idx  in  TW  thread being rolled back
dx_instruction_valid  out  1  result valid, single-cycle pulse
dx_result  out  NUM_LANES*DATA_WIDTH  per-lane quotient/remainder
dx_mask_value  out  NUM_LANES  captured mask
dx_thread_idx  out  TW  captured thread
dx_dest_reg  out  5  captured destination
dx_busy  out  1  operation in flight (for performance counters)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; dx_ready=1; dx_instruction_valid=0; dx_busy=0; dx_result, dx_mask_value, dx_thread_idx, dx_dest_reg=0. Reset mid-operation aborts immediately and produces no output.
- Accept rule: accept on a clock edge when of_instruction_valid && dx_ready && !(wb_rollback_en && wb_rollback_thread_idx==of_thread_idx). A squashed input is dropped silently.
- States: IDLE -> ITERATE -> FIXUP -> DONE -> IDLE.
- IDLE, on accept: capture mask, thread, dest reg and op. For signed ops, per lane take |dividend| and |divisor|. Record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a). Clear partial remainder. Set iteration counter to DATA_WIDTH-1. Go to ITERATE. dx_ready=0 from this edge.
- ITERATE: each cycle, per lane: shift {rem, quot} left 1; trial = rem - divisor (DATA_WIDTH+1 bits). If non-negative, commit and set quotient LSB. Counter decrements. At counter==0, go to FIXUP. Exactly DATA_WIDTH cycles are spent here.
- FIXUP (1 cycle): apply sign corrections (two's-complement negate). Select quotient or remainder into dx_result. Go to DONE.
- DONE: dx_instruction_valid=1 for exactly this cycle and dx_ready=1. The next edge returns to IDLE.
- Latency: the valid cycle starts DATA_WIDTH+2 edges after the accepting edge (34 at default). Back-to-back accept is allowed in the DONE cycle.
- Divide by zero, per lane: quotient = all ones; remainder = dividend. Signed or unsigned, no trap.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Masked-off lanes still compute. The mask is only forwarded, never gates results.
- Rollback: wb_rollback_en with thread matching the captured thread while in ITERATE or FIXUP aborts to IDLE, with no valid pulse. dx_ready=1 on the next cycle. Rollback of a different thread has no effect.
- Rollback in DONE for the same thread suppresses dx_instruction_valid in that cycle.
- dx_busy = (state != IDLE && state != DONE).

Decomposition:
- defines package:
  - div_op_t: 2-bit enum DIV_U, REM_U, DIV_S, REM_S.
  - PIPE_INT_DIV pipeline select.
  - localparam DIV_LATENCY = DATA_WIDTH+2.
- Sub-module int_divide_lane: one instance per lane, generated. Holds the lane's rem/quot/divisor registers and sign flags, and performs one restoring step per enable.
- The top level owns the FSM, counter, handshake, rollback and the passthrough registers.

Test Plan:
- Unsigned quotient, lanes 0..15: a=100+lane, b=7 -> dx_result lane0=14, lane15=16. Valid exactly 34 cycles after accept. dx_ready low throughout.
- Signed remainder: a=-7, b=2 -> remainder -1. a=7, b=-2 -> remainder 1. Signed quotient for a=-7, b=2 -> -3.
- Boundaries: b=0, a=5, DIV_U -> 0xFFFFFFFF. Same inputs, REM_U -> 5. a=0x80000000, b=-1, DIV_S -> 0x80000000; REM_S -> 0.
- Rollback abort: accept on thread 2, then at cycle 10 assert rollback thread 2 -> no valid pulse, dx_ready=1 next cycle. Repeat with rollback thread 1 -> completes normally.
- Back-to-back: present a new instruction in the DONE cycle -> accepted that edge. Second result arrives 34 cycles later. Mask 0x00FF and dest 9 are passed through unchanged.
- Reset mid-operation at cycle 20 -> all outputs at reset values immediately, no later valid. A fresh request afterwards completes correctly.
